// File: rtl/jk_counter_register.sv
// Multi-bit JK register with load, modulo up/down count and registered Wrap/Changed pulses.
// Optional macro JK_COUNTER_SATURATE_EN: counting stops at the limits instead of wrapping.
module jk_counter_register #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned MAX_VALUE   = 9,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             Enable,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] Load_Data,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic             Wrap,
  output logic             Changed
);

  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] RESET_Q = WIDTH'(RESET_VALUE);

  localparam logic [1:0] MODE_JK   = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_UP   = 2'b10;
  localparam logic [1:0] MODE_DOWN = 2'b11;

  logic [WIDTH-1:0] q_next;
  logic             wrap_next;

  // Next-state selection; a limit hit in either count direction raises wrap_next.
  always_comb begin
    q_next    = Q;
    wrap_next = 1'b0;
    if (Enable) begin
      case (Mode)
        MODE_JK:   q_next = (J & ~Q) | (~K & Q);
        MODE_LOAD: q_next = Load_Data;
        MODE_UP: begin
          if (Q >= MAX_Q) begin
`ifdef JK_COUNTER_SATURATE_EN
            q_next = MAX_Q;
`else
            q_next = '0;
`endif
            wrap_next = 1'b1;
          end else begin
            q_next = Q + WIDTH'(1);
          end
        end
        MODE_DOWN: begin
          if (Q == '0) begin
`ifdef JK_COUNTER_SATURATE_EN
            q_next = '0;
`else
            q_next = MAX_Q;
`endif
            wrap_next = 1'b1;
          end else begin
            q_next = Q - WIDTH'(1);
          end
        end
        default: q_next = Q;
      endcase
    end
  end

  // Qbar is registered from the same next value so it can never disagree with Q.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      Q       <= RESET_Q;
      Qbar    <= ~RESET_Q;
      Wrap    <= 1'b0;
      Changed <= 1'b0;
    end else begin
      Q       <= q_next;
      Qbar    <= ~q_next;
      Wrap    <= wrap_next;
      Changed <= (q_next != Q);
    end
  end

endmodule

// File: tb/tb_jk_counter_register.sv
// Randomised and directed bench for jk_counter_register against an arithmetic reference model.
module tb_jk_counter_register;

  localparam int WIDTH = 4;
  localparam int MAXV  = 9;
  localparam int RSTV  = 0;
  localparam int MASK  = (1 << WIDTH) - 1;
`ifdef JK_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             Clock = 1'b0;
  logic             Clear = 1'b0;
  logic             Enable = 1'b0;
  logic [1:0]       Mode = 2'b00;
  logic [WIDTH-1:0] J = '0;
  logic [WIDTH-1:0] K = '0;
  logic [WIDTH-1:0] Load_Data = '0;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Qbar;
  logic             Wrap;
  logic             Changed;

  jk_counter_register #(.WIDTH(WIDTH), .MAX_VALUE(MAXV), .RESET_VALUE(RSTV)) dut (
    .Clock(Clock), .Clear(Clear), .Enable(Enable), .Mode(Mode),
    .J(J), .K(K), .Load_Data(Load_Data),
    .Q(Q), .Qbar(Qbar), .Wrap(Wrap), .Changed(Changed)
  );

  always #5 Clock = ~Clock;

  int tests = 0;
  int fails = 0;
  int m_q   = 0;
  int exp_q = 0;
  bit exp_wrap = 1'b0;
  bit exp_chg  = 1'b0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model's prediction for this edge.
  always @(posedge Clock) begin
    #1;
    if (checking) begin
      chk("Q", 32'(Q), 32'(exp_q));
      chk("Qbar", 32'(Qbar), 32'((~exp_q) & MASK));
      chk("Wrap", 32'(Wrap), 32'(exp_wrap));
      chk("Changed", 32'(Changed), 32'(exp_chg));
    end
  end

  // Apply one edge of stimulus and predict the outcome from the behavioural rules.
  task automatic drive(input bit clr, input bit en, input logic [1:0] md,
                       input logic [WIDTH-1:0] j, input logic [WIDTH-1:0] k,
                       input logic [WIDTH-1:0] ld);
    int cur;
    int nxt;
    bit w;
    @(negedge Clock);
    Clear = clr; Enable = en; Mode = md; J = j; K = k; Load_Data = ld;
    cur = m_q;
    nxt = cur;
    w   = 1'b0;
    if (clr) begin
      nxt = RSTV;
    end else if (en) begin
      case (md)
        2'd0: for (int i = 0; i < WIDTH; i++) begin
          if (j[i] && k[i]) nxt = nxt ^ (1 << i);
          else if (j[i])    nxt = nxt | (1 << i);
          else if (k[i])    nxt = nxt & ~(1 << i);
        end
        2'd1: nxt = int'(ld);
        2'd2: if (cur >= MAXV) begin nxt = SAT ? MAXV : 0; w = 1'b1; end
              else nxt = (cur + 1) % (1 << WIDTH);
        default: if (cur == 0) begin nxt = SAT ? 0 : MAXV; w = 1'b1; end
                 else nxt = cur - 1;
      endcase
    end
    exp_q    = nxt;
    exp_wrap = w;
    exp_chg  = !clr && (nxt != cur);
    m_q      = nxt;
    checking = 1'b1;
    @(posedge Clock);
    #2;
  endtask

  task automatic lit(input string name, input int q, input bit w, input bit c);
    chk({name, ".Q"}, 32'(Q), 32'(q));
    chk({name, ".model"}, 32'(exp_q), 32'(q));
    chk({name, ".Wrap"}, 32'(Wrap), 32'(w));
    chk({name, ".Changed"}, 32'(Changed), 32'(c));
  endtask

  initial begin
    int up_seq [12];
    int dn_seq [4];
    up_seq = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    dn_seq = '{1, 0, 9, 8};

    // Reset with busy inputs, then release with Enable low.
    repeat (2) drive(1, 1, 2'($urandom_range(3)), 4'($urandom), 4'($urandom), 4'($urandom));
    lit("reset", 0, 0, 0);
    chk("reset.Qbar", 32'(Qbar), 32'hF);
    drive(0, 0, 2'd2, 4'hF, 4'h0, 4'h7);
    lit("release", 0, 0, 0);

    // JK truth table
    drive(0, 1, 2'd0, 4'b1010, 4'b0000, 4'h3); lit("jk_set", 4'b1010, 0, 1);
    drive(0, 1, 2'd0, 4'b1111, 4'b1111, 4'h3); lit("jk_tog", 4'b0101, 0, 1);
    drive(0, 1, 2'd0, 4'b0000, 4'b0100, 4'h3); lit("jk_rst", 4'b0001, 0, 1);
    drive(0, 1, 2'd0, 4'b0000, 4'b0000, 4'h3); lit("jk_hold", 4'b0001, 0, 0);

`ifndef JK_COUNTER_SATURATE_EN
    drive(1, 0, 2'd0, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 12; i++) begin
      if (i == 5) begin
        repeat (3) begin
          drive(0, 0, 2'd2, 4'($urandom), 4'($urandom), 4'($urandom));
          lit("up_frozen", 5, 0, 0);
        end
      end
      drive(0, 1, 2'd2, 4'($urandom), 4'($urandom), 4'($urandom));
      lit("up", up_seq[i], up_seq[i] == 0, 1);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 2'd3, 4'($urandom), 4'($urandom), 4'($urandom));
      lit("down", dn_seq[i], dn_seq[i] == 9, 1);
    end
    drive(0, 1, 2'd1, 4'h0, 4'h0, 4'b1101); lit("load13", 13, 0, 1);
    drive(0, 1, 2'd2, 4'h0, 4'h0, 4'h0);    lit("up_oor", 0, 1, 1);
    drive(0, 1, 2'd1, 4'h0, 4'h0, 4'b1101); lit("load13b", 13, 0, 1);
    drive(0, 1, 2'd3, 4'h0, 4'h0, 4'h0);    lit("down_oor", 12, 0, 1);
    drive(0, 1, 2'd1, 4'h0, 4'h0, 4'b1100); lit("load_same", 12, 0, 0);
`else
    drive(0, 1, 2'd1, 4'h0, 4'h0, 4'd8);    lit("sat_load8", 8, 0, 1);
    drive(0, 1, 2'd2, 4'h0, 4'h0, 4'h0);    lit("sat_up1", 9, 0, 1);
    drive(0, 1, 2'd2, 4'h0, 4'h0, 4'h0);    lit("sat_up2", 9, 1, 0);
    drive(0, 1, 2'd2, 4'h0, 4'h0, 4'h0);    lit("sat_up3", 9, 1, 0);
    drive(1, 1, 2'd2, 4'h0, 4'h0, 4'h0);    lit("sat_clear", 0, 0, 0);
    drive(0, 1, 2'd1, 4'h0, 4'h0, 4'd1);    lit("sat_load1", 1, 0, 1);
    drive(0, 1, 2'd3, 4'h0, 4'h0, 4'h0);    lit("sat_dn1", 0, 0, 1);
    drive(0, 1, 2'd3, 4'h0, 4'h0, 4'h0);    lit("sat_dn2", 0, 1, 0);
    drive(0, 1, 2'd1, 4'h0, 4'h0, 4'd13);   lit("sat_load13", 13, 0, 1);
    drive(0, 1, 2'd2, 4'h0, 4'h0, 4'h0);    lit("sat_up_oor", 9, 1, 1);
`endif

    // Random traffic, checked every cycle by the compare process.
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(19) == 0, $urandom_range(3) != 0, 2'($urandom_range(3)),
            4'($urandom), 4'($urandom), 4'($urandom));
    end

    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jk_counter_register.md
Name: jk_counter_register

Overview:
- Parametrised, JK-based multi-bit register that generalises the single master-slave JK flip-flop to WIDTH bits.
- Adds load, up-count and down-count modes with a programmable modulus, plus registered wrap and change status pulses.
- Intended as the reusable storage/counter primitive for the counter and sequencer blocks that come next.
- All state updates on the rising edge of Clock.

Parameters:
- WIDTH, 4, number of JK bits in Q.
- MAX_VALUE, 9, highest count value. Count-up wraps after it; count-down wraps to it. Legal range 1 .. 2^WIDTH-1.
- RESET_VALUE, 0, value loaded into Q by Clear. Must be <= MAX_VALUE.

Ports:
- Clock, input, 1, rising-edge clock.
- Clear, input, 1, synchronous, active-high reset. Highest priority.
- Enable, input, 1, 1 = perform Mode operation at this edge; 0 = hold.
- Mode, input, 2, 00 JK, 01 load, 10 count-up, 11 count-down.
- J, input, WIDTH, per-bit J inputs (used in JK mode only).
- K, input, WIDTH, per-bit K inputs (used in JK mode only).
- Load_Data, input, WIDTH, parallel load value (used in load mode only).
- Q, output, WIDTH, registered state.
- Qbar, output, WIDTH, bitwise complement of Q; always equals ~Q, including in reset.
- Wrap, output, 1, registered one-cycle pulse after a wrap event.
- Changed, output, 1, registered one-cycle pulse after any edge at which Q changed value.

Behaviour:
- Reset: Clock and Clear as above; reset is synchronous and active-high. When Clear=1 at a rising edge: Q=RESET_VALUE, Qbar=~RESET_VALUE, Wrap=0, Changed=0. Clear overrides Enable and Mode.
- No asynchronous paths. Clear asserted mid-operation takes effect at the next edge only; a wrap in progress is discarded (Wrap=0).
- Enable=0 (and Clear=0): Q holds; Wrap=0 and Changed=0 at that edge.
- Mode 00, JK, per bit i:
  - J=0, K=0: hold.
  - J=0, K=1: Q[i]<=0.
  - J=1, K=0: Q[i]<=1.
  - J=1, K=1: Q[i] toggles.
  - JK mode never asserts Wrap. It may produce values above MAX_VALUE.
- Mode 01, load: Q<=Load_Data, full WIDTH, no clamping. Load never asserts Wrap.
- Mode 10, count-up:
  - If Q>=MAX_VALUE: Q<=0 and Wrap<=1.
  - Otherwise Q<=Q+1.
  - Out-of-range values (Q>MAX_VALUE, reachable via load/JK) therefore wrap to 0 on the next up-count.
- Mode 11, count-down:
  - If Q==0: Q<=MAX_VALUE and Wrap<=1.
  - If Q>MAX_VALUE: Q<=Q-1, no wrap.
  - Otherwise Q<=Q-1.
- Count arithmetic is modulo 2^WIDTH internally; results never exceed WIDTH bits.
- Latency:
  - Q updates one edge after the inputs are sampled.
  - Wrap and Changed are valid in the same cycle as the new Q (registered alongside Q).
  - Both are high for exactly one cycle per event. Consecutive events give back-to-back highs; with MAX_VALUE=1, continuous count-up gives Changed held high every cycle.
- Changed<=1 iff the next Q differs from the current Q (Clear excluded). Examples: load of an equal value gives Changed=0; JK with all J=K=0 gives Changed=0.
- Simultaneous inputs: J, K and Load_Data are ignored outside their own modes. Mode changes take effect at the very next enabled edge, with no pipeline flush.

Optional Feature:
- Macro: JK_COUNTER_SATURATE_EN.
- Defined:
  - Count-up at Q>=MAX_VALUE loads MAX_VALUE (saturates).
  - Count-down at Q==0 holds 0.
  - Wrap pulses on each such limited step, meaning "limit hit".
  - Changed follows the normal rule; e.g. up-count at Q>MAX_VALUE loads MAX_VALUE and gives Changed=1.
- Undefined: wrap-around behaviour as specified in Behaviour.
- JK and load modes are unaffected either way.

Test Plan (WIDTH=4, MAX_VALUE=9, RESET_VALUE=0, macro undefined unless stated):
- Clear=1 for 2 edges with random J/K/Mode/Enable=1 -> Q=0000, Qbar=1111, Wrap=0, Changed=0. Release Clear with Enable=0 -> Q stays 0000.
- Mode=00, Q=0000:
  - J=1010, K=0000 -> Q=1010, Changed=1.
  - then J=1111, K=1111 -> Q=0101.
  - then J=0000, K=0100 -> Q=0001.
  - then J=K=0000 -> Q=0001, Changed=0.
- Mode=10 from Q=0, Enable=1 for 12 edges -> Q goes 1..9, 0, 1, 2. Wrap high only in the cycle Q becomes 0. Enable=0 for 3 edges mid-sequence -> Q frozen, Wrap=Changed=0.
- Mode=11 from Q=2 -> Q goes 1, 0, 9 (Wrap=1 with the 9), 8.
- Load Load_Data=1101 -> Q=1101, Wrap=0. Mode=10 next edge -> Q=0000, Wrap=1. Separately, load 1101 then Mode=11 -> Q=1100, Wrap=0. Load of the value already held -> Changed=0.
- With JK_COUNTER_SATURATE_EN:
  - Count-up from 8 -> 9, 9, 9, with Wrap=1 on the 2nd and 3rd steps and Changed=0 there.
  - Count-down from 1 -> 0, 0, with Wrap=1 on the 2nd step.
  - Clear asserted during saturation -> Q=0000, Wrap=0 next cycle.
